// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ENTRY_SIZE_DEF = 4;
   localparam int unsigned ENTRY_RANGE    = 1 << ENTRY_SIZE_DEF;
   localparam int unsigned TAG_W_DEF      = ENTRY_SIZE_DEF + 1;
   localparam logic [TAG_W_DEF-1:0] ENTRY_NULL = TAG_W_DEF'(ENTRY_RANGE);

   localparam int unsigned REG_W = 6;
   localparam int unsigned XLEN  = 32;
   localparam logic [REG_W-1:0] REG_NULL = 6'd32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      K_ALU    = 2'd0,
      K_BRANCH = 2'd1,
      K_STORE  = 2'd2
   } kind_e;

   // Payload held per in-flight instruction
   typedef struct packed {
      kind_e             kind;
      logic [REG_W-1:0]  rd;
      logic [XLEN-1:0]   pc;
      logic              pred_taken;
      logic [XLEN-1:0]   result;
      logic              taken;
      logic [XLEN-1:0]   target;
   } rob_slot_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, in-order retire, mispredict flush.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ENTRY_SIZE = ENTRY_SIZE_DEF,
   parameter int unsigned TAG_W      = ENTRY_SIZE + 1
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              issue_valid,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic [1:0]        issue_kind,
   input  logic [XLEN-1:0]   issue_pc,
   input  logic              issue_pred_taken,
   output logic              rob_full,
   output logic [TAG_W-1:0]  rob_new_entry,
   output logic              new_issue,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [XLEN-1:0]   cdb_result,
   input  logic              cdb_taken,
   input  logic [XLEN-1:0]   cdb_target,
   input  logic [TAG_W-1:0]  qj_tag,
   input  logic [TAG_W-1:0]  qk_tag,
   output logic              qj_ready,
   output logic              qk_ready,
   output logic [XLEN-1:0]   qj_value,
   output logic [XLEN-1:0]   qk_value,
   output logic              rob_commit,
   output logic [TAG_W-1:0]  rob_entry,
   output logic [REG_W-1:0]  rob_des,
   output logic [XLEN-1:0]   rob_result,
   output logic              store_commit,
   output logic              roll_back,
   output logic [XLEN-1:0]   roll_back_pc
);

   localparam int unsigned DEPTH = 1 << ENTRY_SIZE;
   localparam int unsigned CNT_W = ENTRY_SIZE + 1;

   logic [ENTRY_SIZE-1:0] head;
   logic [ENTRY_SIZE-1:0] tail;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_next;
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      ready;
   rob_slot_t             slot [DEPTH];

   rob_slot_t             head_slot;
   logic                  commit_fire;
   logic                  mispredict;
   logic                  wb_hit;
   logic [ENTRY_SIZE-1:0] wb_idx;
   logic [ENTRY_SIZE-1:0] qj_idx;
   logic [ENTRY_SIZE-1:0] qk_idx;

   // A tag names a real entry only when every bit above the index is clear
   function automatic logic tag_ok(input logic [TAG_W-1:0] t);
      return t[TAG_W-1:ENTRY_SIZE] == '0;
   endfunction

   assign rob_full      = (count == CNT_W'(DEPTH));
   assign rob_new_entry = TAG_W'(tail);
   assign new_issue     = issue_valid && !rob_full && !roll_back && rdy_in;

   assign head_slot   = slot[head];
   assign commit_fire = rdy_in && !roll_back && busy[head] && ready[head];
   assign mispredict  = commit_fire && (head_slot.kind == K_BRANCH)
                        && (head_slot.taken != head_slot.pred_taken);
   assign wb_idx      = cdb_tag[ENTRY_SIZE-1:0];
   assign wb_hit      = rdy_in && cdb_valid && tag_ok(cdb_tag) && busy[wb_idx];
   assign count_next  = count + CNT_W'(new_issue) - CNT_W'(commit_fire);
   assign qj_idx      = qj_tag[ENTRY_SIZE-1:0];
   assign qk_idx      = qk_tag[ENTRY_SIZE-1:0];

   // Entry array, pointers and occupancy; a mispredict commit empties everything
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         ready <= '0;
         for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      end else if (rdy_in) begin
         if (wb_hit) begin
            ready[wb_idx]        <= TRUE;
            slot[wb_idx].result  <= cdb_result;
            slot[wb_idx].taken   <= cdb_taken;
            slot[wb_idx].target  <= cdb_target;
         end
         if (new_issue) begin
            busy[tail]  <= TRUE;
            ready[tail] <= FALSE;
            slot[tail]  <= '{kind: kind_e'(issue_kind), rd: issue_rd, pc: issue_pc,
                             pred_taken: issue_pred_taken, result: '0, taken: 1'b0,
                             target: '0};
            tail <= tail + ENTRY_SIZE'(1);
         end
         if (commit_fire) begin
            busy[head] <= FALSE;
            head       <= head + ENTRY_SIZE'(1);
         end
         count <= count_next;
         if (mispredict) begin
            busy  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end
      end
   end

   // Registered retire, store and flush outputs
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         rob_commit   <= FALSE;
         store_commit <= FALSE;
         roll_back    <= FALSE;
         rob_entry    <= TAG_W'(DEPTH);
         rob_des      <= REG_NULL;
         rob_result   <= '0;
         roll_back_pc <= '0;
      end else if (!rdy_in) begin
         rob_commit   <= FALSE;
         store_commit <= FALSE;
         roll_back    <= FALSE;
      end else begin
         rob_commit   <= commit_fire;
         store_commit <= commit_fire && (head_slot.kind == K_STORE);
         roll_back    <= mispredict;
         if (commit_fire) begin
            rob_entry  <= TAG_W'(head);
            rob_des    <= head_slot.rd;
            rob_result <= head_slot.result;
         end
         if (mispredict) begin
            roll_back_pc <= head_slot.taken ? head_slot.target : head_slot.pc + 32'd4;
         end
      end
   end

   // Operand forward for the j source: stored result first, then the live CDB
   always_comb begin
      qj_ready = 1'b0;
      qj_value = '0;
      if (tag_ok(qj_tag) && busy[qj_idx] && ready[qj_idx]) begin
         qj_ready = 1'b1;
         qj_value = slot[qj_idx].result;
      end else if (cdb_valid && tag_ok(cdb_tag) && (cdb_tag == qj_tag)) begin
         qj_ready = 1'b1;
         qj_value = cdb_result;
      end
   end

   // Operand forward for the k source
   always_comb begin
      qk_ready = 1'b0;
      qk_value = '0;
      if (tag_ok(qk_tag) && busy[qk_idx] && ready[qk_idx]) begin
         qk_ready = 1'b1;
         qk_value = slot[qk_idx].result;
      end else if (cdb_valid && tag_ok(cdb_tag) && (cdb_tag == qk_tag)) begin
         qk_ready = 1'b1;
         qk_value = cdb_result;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, corner sequences, random vs queue model.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic        clk;
   logic        rst_in;
   logic        rdy_in;
   logic        issue_valid;
   logic [5:0]  issue_rd;
   logic [1:0]  issue_kind;
   logic [31:0] issue_pc;
   logic        issue_pred_taken;
   logic        rob_full;
   logic [4:0]  rob_new_entry;
   logic        new_issue;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_result;
   logic        cdb_taken;
   logic [31:0] cdb_target;
   logic [4:0]  qj_tag;
   logic [4:0]  qk_tag;
   logic        qj_ready;
   logic        qk_ready;
   logic [31:0] qj_value;
   logic [31:0] qk_value;
   logic        rob_commit;
   logic [4:0]  rob_entry;
   logic [5:0]  rob_des;
   logic [31:0] rob_result;
   logic        store_commit;
   logic        roll_back;
   logic [31:0] roll_back_pc;

   reorder_buffer dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_kind(issue_kind),
      .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
      .rob_full(rob_full), .rob_new_entry(rob_new_entry), .new_issue(new_issue),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_ready(qj_ready), .qk_ready(qk_ready),
      .qj_value(qj_value), .qk_value(qk_value),
      .rob_commit(rob_commit), .rob_entry(rob_entry), .rob_des(rob_des),
      .rob_result(rob_result), .store_commit(store_commit),
      .roll_back(roll_back), .roll_back_pc(roll_back_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: in-order queue of in-flight instructions
   typedef struct {
      int          tag;
      bit          rdy;
      logic [1:0]  kind;
      logic [5:0]  rd;
      logic [31:0] pc;
      bit          pred;
      logic [31:0] res;
      bit          tk;
      logic [31:0] tgt;
   } ment_t;

   ment_t       mq[$];
   int          mtail;
   bit          m_rb;
   bit          e_commit, e_store, e_rb;
   logic [4:0]  e_entry;
   logic [5:0]  e_des;
   logic [31:0] e_result, e_rbpc;

   task automatic m_reset();
      mq.delete();
      mtail = 0; m_rb = 0;
      e_commit = 0; e_store = 0; e_rb = 0;
      e_entry = 5'd16; e_des = 6'd32; e_result = '0; e_rbpc = '0;
   endtask

   task automatic fwd(input int t, output bit r, output logic [31:0] v);
      r = 0; v = '0;
      if (t < 16) begin
         foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) begin r = 1; v = mq[i].res; end
         if (!r && cdb_valid && int'(cdb_tag) == t) begin r = 1; v = cdb_result; end
      end
   endtask

   task automatic model_edge(input bit ni);
      ment_t h;
      bit    do_c;
      if (!rdy_in) begin
         e_commit = 0; e_store = 0; e_rb = 0; m_rb = 0;
         return;
      end
      do_c = !m_rb && mq.size() > 0 && mq[0].rdy;
      if (do_c) h = mq[0];
      if (cdb_valid && cdb_tag < 5'd16)
         foreach (mq[i]) if (mq[i].tag == int'(cdb_tag)) begin
            mq[i].rdy = 1; mq[i].res = cdb_result; mq[i].tk = cdb_taken; mq[i].tgt = cdb_target;
         end
      if (ni) begin
         mq.push_back('{tag: mtail, rdy: 0, kind: issue_kind, rd: issue_rd, pc: issue_pc,
                        pred: issue_pred_taken, res: '0, tk: 0, tgt: '0});
         mtail = (mtail + 1) % 16;
      end
      e_commit = do_c; e_store = 0; e_rb = 0;
      if (do_c) begin
         void'(mq.pop_front());
         e_entry = 5'(h.tag); e_des = h.rd; e_result = h.res;
         e_store = (h.kind == 2'd2);
         if (h.kind == 2'd1 && h.tk != h.pred) begin
            e_rb = 1;
            e_rbpc = h.tk ? h.tgt : h.pc + 32'd4;
            mq.delete();
            mtail = 0;
         end
      end
      m_rb = e_rb;
   endtask

   // Snapshots of combinational outputs taken just before the edge
   bit          s_ni, s_full, s_qjr, s_qkr;
   logic [4:0]  s_ne;
   logic [31:0] s_qjv, s_qkv;

   task automatic cycle();
      bit          full_x, ni_x, xr;
      logic [31:0] xv;
      #2;
      full_x = (mq.size() == 16);
      ni_x   = issue_valid && !full_x && !m_rb && rdy_in;
      chk("rob_full", 64'(rob_full), 64'(full_x));
      chk("new_issue", 64'(new_issue), 64'(ni_x));
      chk("rob_new_entry", 64'(rob_new_entry), 64'(mtail));
      fwd(int'(qj_tag), xr, xv);
      chk("qj_ready", 64'(qj_ready), 64'(xr));
      chk("qj_value", 64'(qj_value), 64'(xv));
      fwd(int'(qk_tag), xr, xv);
      chk("qk_ready", 64'(qk_ready), 64'(xr));
      chk("qk_value", 64'(qk_value), 64'(xv));
      s_ni = new_issue; s_full = rob_full; s_ne = rob_new_entry;
      s_qjr = qj_ready; s_qjv = qj_value; s_qkr = qk_ready; s_qkv = qk_value;
      model_edge(ni_x);
      @(posedge clk); #1;
      chk("rob_commit", 64'(rob_commit), 64'(e_commit));
      chk("store_commit", 64'(store_commit), 64'(e_store));
      chk("roll_back", 64'(roll_back), 64'(e_rb));
      chk("rob_entry", 64'(rob_entry), 64'(e_entry));
      chk("rob_des", 64'(rob_des), 64'(e_des));
      chk("rob_result", 64'(rob_result), 64'(e_result));
      chk("roll_back_pc", 64'(roll_back_pc), 64'(e_rbpc));
   endtask

   task automatic idle();
      rdy_in = 1; issue_valid = 0; issue_rd = 6'd32; issue_kind = 2'd0; issue_pc = '0;
      issue_pred_taken = 0; cdb_valid = 0; cdb_tag = 5'd16; cdb_result = '0;
      cdb_taken = 0; cdb_target = '0; qj_tag = 5'd16; qk_tag = 5'd16;
   endtask

   task automatic issue(input logic [5:0] rd, input logic [1:0] k, input logic [31:0] pc,
                        input bit pred);
      idle();
      issue_valid = 1; issue_rd = rd; issue_kind = k; issue_pc = pc; issue_pred_taken = pred;
   endtask

   task automatic cdb(input logic [4:0] t, input logic [31:0] r, input bit tk,
                      input logic [31:0] tg);
      idle();
      cdb_valid = 1; cdb_tag = t; cdb_result = r; cdb_taken = tk; cdb_target = tg;
   endtask

   // Asynchronous reset in the middle of a cycle, checked before any clock edge
   task automatic do_reset();
      idle();
      rst_in = 0;
      #2;
      m_reset();
      chk("rst_rob_full", 64'(rob_full), 64'(0));
      chk("rst_new_entry", 64'(rob_new_entry), 64'(0));
      chk("rst_rob_commit", 64'(rob_commit), 64'(0));
      chk("rst_store_commit", 64'(store_commit), 64'(0));
      chk("rst_roll_back", 64'(roll_back), 64'(0));
      chk("rst_rob_entry", 64'(rob_entry), 64'(16));
      chk("rst_rob_des", 64'(rob_des), 64'(32));
      chk("rst_rob_result", 64'(rob_result), 64'(0));
      chk("rst_roll_back_pc", 64'(roll_back_pc), 64'(0));
      @(posedge clk); #1;
      rst_in = 1;
   endtask

   // ---------------- directed table
   typedef struct {
      bit          iv;
      logic [5:0]  rd;
      bit          cv;
      logic [4:0]  ctag;
      logic [31:0] cres;
      logic [4:0]  x_ne;
      bit          x_com;
      logic [4:0]  x_ent;
      logic [5:0]  x_des;
      logic [31:0] x_res;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(bit iv, logic [5:0] rd, bit cv, logic [4:0] ctag,
                               logic [31:0] cres, logic [4:0] x_ne, bit x_com,
                               logic [4:0] x_ent, logic [5:0] x_des, logic [31:0] x_res);
      return '{iv: iv, rd: rd, cv: cv, ctag: ctag, cres: cres, x_ne: x_ne, x_com: x_com,
               x_ent: x_ent, x_des: x_des, x_res: x_res};
   endfunction

   initial begin
      int nr[$];
      int pick;

      // single issue/complete/commit, then out-of-order writeback 3,2,1
      vq.push_back(mk(1, 6'd5, 0, 5'd16, 32'h0,        5'd0, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 1, 5'd0, 32'hDEADBEEF, 5'd1, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 0, 5'd16, 32'h0,       5'd1, 1, 5'd0, 6'd5, 32'hDEADBEEF));
      vq.push_back(mk(1, 6'd1, 0, 5'd16, 32'h0,        5'd1, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(1, 6'd2, 0, 5'd16, 32'h0,        5'd2, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(1, 6'd3, 0, 5'd16, 32'h0,        5'd3, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 1, 5'd3, 32'h33,       5'd4, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 1, 5'd2, 32'h22,       5'd4, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 1, 5'd1, 32'h11,       5'd4, 0, 5'd0, 6'd0, 32'h0));
      vq.push_back(mk(0, 6'd32, 0, 5'd16, 32'h0,       5'd4, 1, 5'd1, 6'd1, 32'h11));
      vq.push_back(mk(0, 6'd32, 0, 5'd16, 32'h0,       5'd4, 1, 5'd2, 6'd2, 32'h22));
      vq.push_back(mk(0, 6'd32, 0, 5'd16, 32'h0,       5'd4, 1, 5'd3, 6'd3, 32'h33));
      vq.push_back(mk(0, 6'd32, 0, 5'd16, 32'h0,       5'd4, 0, 5'd0, 6'd0, 32'h0));

      idle();
      rst_in = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      foreach (vq[i]) begin
         idle();
         issue_valid = vq[i].iv; issue_rd = vq[i].rd; issue_pc = 32'h100 + 32'(4 * i);
         cdb_valid = vq[i].cv; cdb_tag = vq[i].ctag; cdb_result = vq[i].cres;
         cycle();
         chk("vec_new_entry", 64'(s_ne), 64'(vq[i].x_ne));
         chk("vec_commit", 64'(rob_commit), 64'(vq[i].x_com));
         if (vq[i].x_com) begin
            chk("vec_entry", 64'(rob_entry), 64'(vq[i].x_ent));
            chk("vec_des", 64'(rob_des), 64'(vq[i].x_des));
            chk("vec_result", 64'(rob_result), 64'(vq[i].x_res));
         end
      end

      // fill to full, refuse the 17th, commit-while-full, wrap to tag 0
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue(6'(i), 2'd0, 32'h1000 + 32'(4 * i), 0);
         cycle();
         chk("fill_tag", 64'(s_ne), 64'(i));
      end
      chk("fill_full", 64'(rob_full), 64'(1));
      issue(6'd20, 2'd0, 32'h2000, 0);
      cycle();
      chk("full_refuse", 64'(s_ni), 64'(0));
      cdb(5'd0, 32'hA5, 0, 32'h0);
      cycle();
      issue(6'd21, 2'd0, 32'h2004, 0);
      cycle();
      chk("full_commit_refuse", 64'(s_ni), 64'(0));
      chk("full_commit", 64'(rob_commit), 64'(1));
      chk("full_commit_entry", 64'(rob_entry), 64'(0));
      issue(6'd22, 2'd0, 32'h2008, 0);
      cycle();
      chk("wrap_accept", 64'(s_ni), 64'(1));
      chk("wrap_tag", 64'(s_ne), 64'(0));
      chk("wrap_full_again", 64'(rob_full), 64'(1));

      // reset with 16 entries in flight
      do_reset();

      // mispredicted branch: taken resolved, predicted not taken
      issue(6'd32, 2'd1, 32'h200, 0);
      cycle();
      issue(6'd7, 2'd0, 32'h204, 0);
      cycle();
      cdb(5'd0, 32'h204, 1, 32'h400);
      cycle();
      issue(6'd8, 2'd0, 32'h208, 0);
      cycle();
      chk("br_commit", 64'(rob_commit), 64'(1));
      chk("br_roll_back", 64'(roll_back), 64'(1));
      chk("br_roll_back_pc", 64'(roll_back_pc), 64'(32'h400));
      issue(6'd9, 2'd0, 32'h400, 0);
      cycle();
      chk("rb_blocks_issue", 64'(s_ni), 64'(0));
      chk("rb_tag_reset", 64'(s_ne), 64'(0));
      chk("rb_pulse_end", 64'(roll_back), 64'(0));
      issue(6'd9, 2'd0, 32'h400, 0);
      cycle();
      chk("post_rb_issue", 64'(s_ni), 64'(1));
      chk("post_rb_tag", 64'(s_ne), 64'(0));

      // forwarding from a stored result and from the live CDB
      do_reset();
      for (int i = 0; i < 5; i++) begin
         issue(6'(10 + i), 2'd0, 32'h300 + 32'(4 * i), 0);
         cycle();
      end
      cdb(5'd3, 32'd7, 0, 32'h0);
      cycle();
      cdb(5'd4, 32'd9, 0, 32'h0);
      qj_tag = 5'd3; qk_tag = 5'd4;
      cycle();
      chk("fwd_qj_ready", 64'(s_qjr), 64'(1));
      chk("fwd_qj_value", 64'(s_qjv), 64'(7));
      chk("fwd_qk_ready", 64'(s_qkr), 64'(1));
      chk("fwd_qk_value", 64'(s_qkv), 64'(9));

      // rdy_in low for three cycles with a ready head
      cdb(5'd0, 32'h55, 0, 32'h0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         issue(6'd30, 2'd0, 32'h500, 0);
         rdy_in = 0;
         cycle();
         chk("stall_no_commit", 64'(rob_commit), 64'(0));
         chk("stall_tail", 64'(s_ne), 64'(5));
      end
      idle();
      cycle();
      chk("stall_release_commit", 64'(rob_commit), 64'(1));
      chk("stall_release_entry", 64'(rob_entry), 64'(0));
      chk("stall_release_result", 64'(rob_result), 64'(32'h55));

      // randomized traffic against the queue model
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         idle();
         rdy_in = ($urandom_range(99) >= 8);
         issue_valid = ($urandom_range(99) < 65);
         issue_rd = 6'($urandom_range(32));
         issue_kind = 2'($urandom_range(2));
         issue_pc = $urandom() & 32'hFFFF_FFFC;
         issue_pred_taken = 1'($urandom_range(1));
         nr.delete();
         foreach (mq[i]) if (!mq[i].rdy) nr.push_back(mq[i].tag);
         if (nr.size() > 0 && $urandom_range(99) < 55) begin
            pick = nr[$urandom_range(nr.size() - 1)];
            cdb_valid = 1; cdb_tag = 5'(pick);
            foreach (mq[i]) if (mq[i].tag == pick) begin
               cdb_taken = ($urandom_range(99) < 85) ? mq[i].pred : 1'($urandom_range(1));
            end
         end else if ($urandom_range(99) < 15) begin
            cdb_valid = 1; cdb_tag = 5'($urandom_range(16));
            cdb_taken = 1'($urandom_range(1));
         end
         cdb_result = $urandom();
         cdb_target = $urandom() & 32'hFFFF_FFFC;
         qj_tag = 5'($urandom_range(16));
         qk_tag = cdb_valid && $urandom_range(1) == 1 ? cdb_tag : 5'($urandom_range(16));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo RISC-V core. It allocates tags to issued instructions and captures results from the common data bus. It retires one instruction per cycle in program order, driving the register file's commit and issue-tag ports. On commit of a mispredicted branch it raises the global `roll_back` flush.

## Interface
Parameters:
- `ENTRY_SIZE`, default 4: log2 of depth; DEPTH = 2^ENTRY_SIZE = 16.
- `TAG_W`, default ENTRY_SIZE+1: tag width; `ENTRY_NULL` = 1<<ENTRY_SIZE (MSB set = no tag).

Ports (reset is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_in` in 1: asynchronous reset, active-low.
- `rdy_in` in 1: global ready; low freezes all state.
- `issue_valid` in 1: dispatcher offers an instruction.
- `issue_rd` in 6: destination register; `REG_NULL` (6'd32) = none.
- `issue_kind` in 2: `K_ALU`, `K_BRANCH`, `K_STORE`.
- `issue_pc` in 32: instruction PC.
- `issue_pred_taken` in 1: predictor decision (branches only).
- `rob_full` out 1: no free entry; issue is refused.
- `rob_new_entry` out TAG_W: tag the next accepted issue receives (= {0,tail}).
- `new_issue` out 1: combinational, issue_valid && !rob_full && !roll_back && rdy_in.
- `cdb_valid` in 1: result broadcast.
- `cdb_tag` in TAG_W: producing entry.
- `cdb_result` in 32: result value (link address for JAL/JALR).
- `cdb_taken` in 1: resolved branch direction.
- `cdb_target` in 32: resolved taken target.
- `qj_tag`, `qk_tag` in TAG_W: operand tags from register file.
- `qj_ready`, `qk_ready` out 1: tagged entry already has a result.
- `qj_value`, `qk_value` out 32: that result.
- `rob_commit` out 1: one-cycle retire pulse.
- `rob_entry` out TAG_W: retired tag.
- `rob_des` out 6: retired rd (REG_NULL if none).
- `rob_result` out 32: retired value.
- `store_commit` out 1: one-cycle pulse, head store retired.
- `roll_back` out 1: one-cycle flush pulse.
- `roll_back_pc` out 32: fetch redirect PC.

## Operation
- Per entry: busy, ready, kind, rd, pc, pred_taken, result, taken, target.
- State: head/tail pointers (ENTRY_SIZE bits, natural wrap); count (ENTRY_SIZE+1 bits).
- Full/empty flags:
  - `rob_full` = (count == DEPTH), from registered count only.
  - Empty = count == 0.
- Issue, when `new_issue`:
  - Entry[tail] becomes busy, not ready.
  - tail+1; count+1.
- Writeback, when `cdb_valid`, `cdb_tag` != ENTRY_NULL and entry busy:
  - Set ready; latch result, taken and target.
  - A writeback to a non-busy entry is ignored.
- Commit fires when entry[head] is busy and ready, at the edge:
  - Set `rob_commit`=1 and `rob_entry`={0,head}.
  - Drive `rob_des` and `rob_result` from the entry.
  - Clear busy; head+1; count-1.
  - For K_STORE, also pulse `store_commit`.
- Mispredict: K_BRANCH commit with taken != pred_taken.
  - Commit normally (rd/result still delivered for JALR/JAL).
  - Also register `roll_back`=1.
  - `roll_back_pc` = taken ? target : pc+4 (mod 2^32).
  - At that same edge, clear all busy bits and set head=tail=count=0.
- Simultaneous issue and commit: count unchanged. If full, issue is still refused that cycle.
- While `roll_back` is high, issue is blocked (`new_issue`=0) and commit is suppressed.
- Operand forward: `qX_ready` = tag != ENTRY_NULL && busy && ready, or the same-cycle CDB hit on that tag.
  - `qX_value` = entry result, or `cdb_result` on a CDB hit.
  - Otherwise `qX_ready`=0 and `qX_value`=0.
- `rdy_in` low: no state changes; registered pulse outputs are driven 0.

## Timing
- Reset (async, `rst_in`=0) clears all entries and pointers.
- Reset values:
  - `rob_commit`, `store_commit`, `roll_back` = 0.
  - `rob_entry` = ENTRY_NULL, `rob_des` = REG_NULL.
  - `rob_result` and `roll_back_pc` = 0.
  - `rob_full` = 0.
- Reset mid-operation discards all in-flight entries.
- Issue-to-earliest-commit latency:
  - Issue at edge N, CDB at N+1 → `rob_commit` high after edge N+2.
  - A CDB write to the head at edge N gives commit at edge N+1.
- Commit, store_commit, roll_back and their data are registered. Each is high exactly one cycle per event.
- Throughput: one issue and one commit per cycle.

## Structure
- Shared package/header, alongside the existing constants:
  - `ENTRY_RANGE`, `ENTRY_NULL`.
  - `REG_NULL` = 6'd32.
  - `K_ALU`/`K_BRANCH`/`K_STORE` encodings.
  - `TRUE`/`FALSE`.
- Single module: entry arrays, pointer/count logic, and the combinational forward mux. No sub-module is needed.

## Test plan
- Reset, then issue rd=5 at pc 0x100. Expect `rob_new_entry`=0. Then CDB tag 0, result 0xDEADBEEF. Expect `rob_commit` with `rob_des`=5, `rob_result`=0xDEADBEEF two edges after issue.
- Out-of-order writeback:
  - Issue tags 0,1,2; CDB completes them as 2, 1, 0.
  - Expect commits in order 0,1,2 on consecutive cycles.
- Fill and wrap:
  - Issue 16 entries → `rob_full`=1; a 17th issue is refused.
  - Commit one while offering issue → still refused that cycle, accepted the next with tag 0.
- Branch at pc 0x200, pred_taken=0, resolved taken=1, target 0x400:
  - Expect `roll_back`=1 and `roll_back_pc`=0x400 at commit.
  - Afterwards count=0 and the next `rob_new_entry`=0.
- Forwarding: `qj_tag`=3 with entry 3 ready holding 7 → `qj_ready`=1, `qj_value`=7. A same-cycle CDB on tag 4 with 9 and `qk_tag`=4 → `qk_ready`=1, `qk_value`=9.
- `rdy_in`=0 for 3 cycles with a ready head: no commit and no pointer change; commit occurs on the first cycle after `rdy_in` returns high.
